// File: rtl/nonce_result_collector_pkg.sv
// Shared types for the bitcoin_hash result drain: FSM states, address and word widths.
package nonce_result_collector_pkg;

  localparam int unsigned NUM_NONCES_DEF = 16;
  localparam int unsigned ADDR_W         = 16;
  localparam int unsigned WORD_W         = 32;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_CAPTURE,
    S_WRITE,
    S_FINISH
  } state_t;

endpackage

// File: rtl/nonce_result_collector_if.sv
// Result memory write port driven by the collector (master) into the result RAM (slave).
interface nonce_result_collector_if;
  import nonce_result_collector_pkg::*;

  logic  mem_clk;
  logic  mem_we;
  addr_t mem_addr;
  word_t mem_write_data;

  modport master (output mem_clk, output mem_we, output mem_addr, output mem_write_data);
  modport slave  (input  mem_clk, input  mem_we, input  mem_addr, input  mem_write_data);

endinterface

// File: rtl/nonce_result_collector.sv
// Launches engine batches, waits for completion, captures each engine's h0 and
// writes the words to memory in nonce order until all nonces are covered.
module nonce_result_collector
  import nonce_result_collector_pkg::*;
#(
  parameter int unsigned NUM_NONCES  = NUM_NONCES_DEF,
  parameter int unsigned NUM_ENGINES = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          go,
  input  addr_t                         output_addr,
  output logic                          eng_start,
  output logic [3:0]                    nonce_base,
  input  logic [NUM_ENGINES-1:0]        eng_valid,
  input  logic [WORD_W*NUM_ENGINES-1:0] eng_hash,
  nonce_result_collector_if.master      mem,
  output logic                          done
);

  localparam int unsigned SLOT_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_ENGINES - 1);

  if ((NUM_NONCES % NUM_ENGINES) != 0 || NUM_NONCES > 16) begin : g_bad_cfg
    $error("NUM_NONCES must be <= 16 and a multiple of NUM_ENGINES");
  end

  state_t              state;
  state_t              state_nx;
  addr_t               base_addr;
  logic [SLOT_W-1:0]   slot;
  word_t               result_buf [NUM_ENGINES];
  logic                last_batch;

  // Widened by one bit so nonce_base + NUM_ENGINES cannot wrap before the compare.
  assign last_batch = ({1'b0, nonce_base} + 5'(NUM_ENGINES)) >= 5'(NUM_NONCES);
  assign mem.mem_clk = clk;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_addr  <= '0;
      nonce_base <= '0;
      slot       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (go) begin
            base_addr  <= output_addr;
            nonce_base <= '0;
          end
        end
        S_CAPTURE: slot <= '0;
        S_WRITE: begin
          slot <= slot + 1'b1;
          if (slot == LAST_SLOT && !last_batch) begin
            nonce_base <= nonce_base + 4'(NUM_ENGINES);
          end
        end
        default: ;
      endcase
    end
  end

  // Buffer needs no reset: it is only read in WRITE, which always follows a CAPTURE.
  always_ff @(posedge clk) begin
    if (state == S_CAPTURE) begin
      for (int unsigned i = 0; i < NUM_ENGINES; i++) begin
        result_buf[i] <= eng_hash[WORD_W*i +: WORD_W];
      end
    end
  end

  always_comb begin
    state_nx           = state;
    eng_start          = 1'b0;
    done               = 1'b0;
    mem.mem_we         = 1'b0;
    mem.mem_addr       = '0;
    mem.mem_write_data = '0;
    case (state)
      S_IDLE:      if (go) state_nx = S_LAUNCH;
      S_LAUNCH: begin
        eng_start = 1'b1;
        state_nx  = S_WAIT_BUSY;
      end
      // Engines hold valid high while idle; wait for it to drop before trusting a rise.
      S_WAIT_BUSY: if (eng_valid == '0) state_nx = S_WAIT_DONE;
      S_WAIT_DONE: if (&eng_valid) state_nx = S_CAPTURE;
      S_CAPTURE:   state_nx = S_WRITE;
      S_WRITE: begin
        mem.mem_we         = 1'b1;
        mem.mem_addr       = base_addr + addr_t'(nonce_base) + addr_t'(slot);
        mem.mem_write_data = result_buf[slot];
        if (slot == LAST_SLOT) state_nx = last_batch ? S_FINISH : S_LAUNCH;
      end
      S_FINISH: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default:     state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_nonce_result_collector.sv
// Scoreboard bench: a 16-engine and a 4-engine collector driven by behavioural engines.
module tb_nonce_result_collector;
  import nonce_result_collector_pkg::*;

  typedef struct {
    addr_t addr;
    word_t data;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic         go16 = 1'b0, go4 = 1'b0;
  addr_t        oaddr16 = '0, oaddr4 = '0;
  logic         start16, start4, done16, done4;
  logic [3:0]   nb16, nb4;
  logic [15:0]  v16;
  logic [3:0]   v4;
  logic [511:0] h16;
  logic [127:0] h4;

  nonce_result_collector_if m16 ();
  nonce_result_collector_if m4 ();

  nonce_result_collector #(.NUM_NONCES(16), .NUM_ENGINES(16)) u16 (
    .clk(clk), .reset_n(reset_n), .go(go16), .output_addr(oaddr16),
    .eng_start(start16), .nonce_base(nb16), .eng_valid(v16), .eng_hash(h16),
    .mem(m16), .done(done16)
  );

  nonce_result_collector #(.NUM_NONCES(16), .NUM_ENGINES(4)) u4 (
    .clk(clk), .reset_n(reset_n), .go(go4), .output_addr(oaddr4),
    .eng_start(start4), .nonce_base(nb4), .eng_valid(v4), .eng_hash(h4),
    .mem(m4), .done(done4)
  );

  int    n_cmp = 0;
  int    n_err = 0;
  exp_t  sbq[$];

  // 16-engine model: common latency, optional stale-high valid, hash scrambled after capture
  int    lat16 = 140;
  int    stale16 = 0;
  word_t pat16 = 32'hA000_0000;
  int    cnt16, post16;
  bit    busy16;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v16 <= '1; busy16 <= 1'b0; cnt16 <= 0; post16 <= 0;
      for (int i = 0; i < 16; i++) h16[32*i +: 32] <= 32'h5A5A_0000 + 32'(i);
    end else if (start16) begin
      busy16 <= 1'b1; cnt16 <= 0; post16 <= 0;
      if (stale16 == 0) v16 <= '0;
    end else if (busy16) begin
      cnt16 <= cnt16 + 1;
      if (cnt16 + 1 == stale16) v16 <= '0;
      if (cnt16 + 1 >= lat16) begin
        busy16 <= 1'b0; v16 <= '1; post16 <= 1;
        for (int i = 0; i < 16; i++) h16[32*i +: 32] <= pat16 + 32'(i);
      end
    end else if (post16 != 0) begin
      post16 <= (post16 == 3) ? 0 : post16 + 1;
      if (post16 == 3)
        for (int i = 0; i < 16; i++) h16[32*i +: 32] <= ~(pat16 + 32'(i));
    end
  end

  // 4-engine model: engine i returns its nonce (nonce_base + i)
  int         cnt4;
  bit         busy4;
  logic [3:0] nbl4;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v4 <= '1; busy4 <= 1'b0; cnt4 <= 0; h4 <= '1; nbl4 <= '0;
    end else if (start4) begin
      busy4 <= 1'b1; cnt4 <= 0; v4 <= '0; nbl4 <= nb4;
    end else if (busy4) begin
      cnt4 <= cnt4 + 1;
      if (cnt4 + 1 >= 20) begin
        busy4 <= 1'b0; v4 <= '1;
        for (int i = 0; i < 4; i++) h4[32*i +: 32] <= 32'(nbl4) + 32'(i);
      end
    end
  end

  bit         sel4 = 1'b0;
  logic       cur_we, cur_start, cur_done;
  addr_t      cur_addr;
  word_t      cur_data;
  logic [3:0] cur_nb;
  assign cur_we    = sel4 ? m4.mem_we         : m16.mem_we;
  assign cur_start = sel4 ? start4            : start16;
  assign cur_done  = sel4 ? done4             : done16;
  assign cur_addr  = sel4 ? m4.mem_addr       : m16.mem_addr;
  assign cur_data  = sel4 ? m4.mem_write_data : m16.mem_write_data;
  assign cur_nb    = sel4 ? nb4               : nb16;

  task automatic run_batch(input bit use4, input addr_t base, input word_t pat, input int ne);
    int   starts = 0, burst = 0, last_we = -10;
    bit   seen_done = 1'b0;
    exp_t e, got;
    sel4 = use4;
    for (int i = 0; i < 16; i++) begin
      e.addr = base + addr_t'(i);
      e.data = use4 ? word_t'(i) : pat + word_t'(i);
      sbq.push_back(e);
    end
    @(negedge clk);
    if (use4) begin oaddr4 = base; go4 = 1'b1; end
    else begin oaddr16 = base; pat16 = pat; go16 = 1'b1; end
    @(negedge clk);
    go4 = 1'b0; go16 = 1'b0;
    n_cmp++;
    if (cur_start !== 1'b1) begin
      n_err++; $display("FAIL go_to_start: eng_start=%b required 1", cur_start);
    end
    for (int cyc = 0; cyc < 1000 && !seen_done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (cur_start) begin
        n_cmp++;
        if (cur_nb !== 4'(starts * ne)) begin
          n_err++; $display("FAIL nonce_base: got %0d required %0d", cur_nb, 4'(starts * ne));
        end
        starts++;
      end
      if (cur_we) begin
        n_cmp++;
        if (sbq.size() == 0) begin
          n_err++; $display("FAIL extra_write: addr=%h data=%h required no write", cur_addr, cur_data);
        end else begin
          got = sbq.pop_front();
          if (cur_addr !== got.addr || cur_data !== got.data) begin
            n_err++;
            $display("FAIL write: addr=%h data=%h required addr=%h data=%h",
                     cur_addr, cur_data, got.addr, got.data);
          end
        end
        burst++; last_we = cyc;
      end else if (burst != 0) begin
        n_cmp++;
        if (burst != ne) begin
          n_err++; $display("FAIL burst_len: got %0d required %0d", burst, ne);
        end
        burst = 0;
      end
      if (cur_done) begin
        seen_done = 1'b1;
        n_cmp++;
        if (last_we != cyc - 1) begin
          n_err++; $display("FAIL done_timing: done at %0d last write %0d required %0d", cyc, last_we, cyc - 1);
        end
      end
    end
    n_cmp++;
    if (!seen_done) begin
      n_err++; $display("FAIL done_seen: no done within budget, required one");
    end
    n_cmp++;
    if (starts != 16 / ne) begin
      n_err++; $display("FAIL start_count: got %0d required %0d", starts, 16 / ne);
    end
    n_cmp++;
    if (sbq.size() != 0) begin
      n_err++; $display("FAIL all_written: %0d words missing required 0", sbq.size());
    end
    sbq.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({m16.mem_addr, m16.mem_write_data, nb16, m4.mem_addr, m4.mem_write_data, nb4} !== '0) begin
      n_err++; $display("FAIL reset_regs: addr16=%h data16=%h nb16=%h addr4=%h data4=%h nb4=%h required 0",
                        m16.mem_addr, m16.mem_write_data, nb16, m4.mem_addr, m4.mem_write_data, nb4);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({start16, start4, m16.mem_we, m4.mem_we, done16, done4} !== 6'b0) begin
        n_err++; $display("FAIL idle_outputs: start/we/done=%b required 000000",
                          {start16, start4, m16.mem_we, m4.mem_we, done16, done4});
      end
    end
  endtask

  task automatic test_full_batch();
    lat16 = 140; stale16 = 0;
    run_batch(1'b0, 16'h0100, 32'hA000_0000, 16);
  endtask

  task automatic test_time_mux();
    run_batch(1'b1, 16'h0000, 32'h0, 4);
  endtask

  task automatic test_stale_valid();
    lat16 = 30; stale16 = 3;
    run_batch(1'b0, 16'h0200, 32'hC000_0000, 16);
    stale16 = 0;
  endtask

  task automatic test_wrap();
    lat16 = 30;
    run_batch(1'b0, 16'hFFF8, 32'hB000_0000, 16);
  endtask

  task automatic test_reset_midrun();
    int writes = 0, guard = 0;
    bit stray = 1'b0;
    sel4 = 1'b0; lat16 = 30;
    @(negedge clk);
    oaddr16 = 16'h0300; pat16 = 32'hD000_0000; go16 = 1'b1;
    @(negedge clk);
    go16 = 1'b0;
    while (writes < 5 && guard < 500) begin
      @(negedge clk);
      guard++;
      if (m16.mem_we) writes++;
    end
    n_cmp++;
    if (writes != 5) begin
      n_err++; $display("FAIL midrun_reach: got %0d writes required 5", writes);
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({m16.mem_we, done16, start16, nb16, m16.mem_addr, m16.mem_write_data} !== '0) begin
      n_err++; $display("FAIL midrun_reset: we=%b done=%b addr=%h data=%h required all 0",
                        m16.mem_we, done16, m16.mem_addr, m16.mem_write_data);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (m16.mem_we || done16) stray = 1'b1;
    end
    n_cmp++;
    if (stray) begin
      n_err++; $display("FAIL abandoned_run: stray write or done=1 required 0");
    end
    run_batch(1'b0, 16'h0300, 32'hE000_0000, 16);
  endtask

  initial begin
    test_reset();
    test_full_batch();
    test_time_mux();
    test_stale_valid();
    test_wrap();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
